// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Digits use 4'hF as the code for a blank display position.
package bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        FIXA
    } estado_t;

    localparam int LARGURA_DIGITO = 4;
    localparam logic [LARGURA_DIGITO-1:0] DIGITO_APAGADO = 4'hF;
    localparam int VALOR_MAXIMO = 9999;

    // Blank digits 3..1 while they and every digit above them are zero.
    function automatic logic [15:0] apaga_zeros(input logic [15:0] bcd);
        logic [15:0] resultado;
        logic        lider;
        resultado = bcd;
        lider     = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            if (lider && (bcd[k*LARGURA_DIGITO +: LARGURA_DIGITO] == 4'h0)) begin
                resultado[k*LARGURA_DIGITO +: LARGURA_DIGITO] = DIGITO_APAGADO;
            end else begin
                lider = 1'b0;
            end
        end
        return resultado;
    endfunction

endpackage

// File: rtl/conversor_bcd_soma3.sv
// Per-digit double-dabble correction: digits of 5 or more get 3 added.
// The add stays inside the digit; there is no carry to the next one.
module soma3
    import bcd_pkg::*;
(
    input  logic [LARGURA_DIGITO-1:0] entrada,
    output logic [LARGURA_DIGITO-1:0] saida
);

    assign saida = (entrada >= 4'd5) ? entrada + 4'd3 : entrada;

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter that loads the four-digit display register.
// One input bit is consumed per clock using shift-and-add-3.
//
// state    | meaning
// ---------+----------------------------------------------------------
// OCIOSO   | idle, pronto high, captures entrada when valido is high
// CONVERTE | one add-3 and shift iteration per edge, LARGURA in total
// FIXA     | loads registrador (overflow/blanking applied), pulses concluido
module conversor_bcd
    import bcd_pkg::*;
#(
    parameter int LARGURA       = 14,
    parameter bit SUPRIME_ZEROS = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] entrada,
    input  logic               valido,
    output logic               pronto,
    output logic [15:0]        registrador,
    output logic               concluido
);

    localparam int CW = $clog2(LARGURA);

    estado_t            estado;
    estado_t            proximo;
    logic [CW-1:0]      contador;
    logic [LARGURA-1:0] desloc;
    logic [15:0]        acumulador;
    logic [15:0]        corrigido;
    logic               excesso;

    for (genvar d = 0; d < 4; d++) begin : g_soma3
        soma3 u_soma3 (
            .entrada (acumulador[d*LARGURA_DIGITO +: LARGURA_DIGITO]),
            .saida   (corrigido[d*LARGURA_DIGITO +: LARGURA_DIGITO])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        pronto  = 1'b0;
        case (estado)
            OCIOSO: begin
                pronto = 1'b1;
                if (valido) begin
                    proximo = CONVERTE;
                end
            end
            CONVERTE: begin
                if (contador == '0) begin
                    proximo = FIXA;
                end
            end
            FIXA:    proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contador    <= '0;
            excesso     <= 1'b0;
            desloc      <= '0;
            acumulador  <= '0;
            registrador <= '0;
            concluido   <= 1'b0;
        end else begin
            concluido <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (valido) begin
                        desloc     <= entrada;
                        acumulador <= '0;
                        contador   <= CW'(LARGURA - 1);
                        excesso    <= ({{(32-LARGURA){1'b0}}, entrada} > 32'(VALOR_MAXIMO));
                    end
                end
                CONVERTE: begin
                    {acumulador, desloc} <= {corrigido, desloc} << 1;
                    if (contador != '0) begin
                        contador <= contador - 1'b1;
                    end
                end
                FIXA: begin
                    if (excesso) begin
                        registrador <= {4{DIGITO_APAGADO}};
                    end else if (SUPRIME_ZEROS) begin
                        registrador <= apaga_zeros(acumulador);
                    end else begin
                        registrador <= acumulador;
                    end
                    concluido <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd.sv
// Scoreboard bench for conversor_bcd: two instances (plain and zero-blanking)
// share stimulus; a monitor pops expected results whenever concluido pulses.
module tb_conversor_bcd;

    logic        clock = 1'b0;
    logic        reset;
    logic        valido;
    logic [13:0] entrada;
    logic        pronto_a, concluido_a, pronto_b, concluido_b;
    logic [15:0] reg_a, reg_b;

    int ecount = 0;
    int n_vec  = 0;
    int n_err  = 0;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } esperado_t;

    esperado_t fila_a[$];
    esperado_t fila_b[$];

    conversor_bcd #(.LARGURA(14), .SUPRIME_ZEROS(1'b0)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .entrada     (entrada),
        .valido      (valido),
        .pronto      (pronto_a),
        .registrador (reg_a),
        .concluido   (concluido_a)
    );

    conversor_bcd #(.LARGURA(14), .SUPRIME_ZEROS(1'b1)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .entrada     (entrada),
        .valido      (valido),
        .pronto      (pronto_b),
        .registrador (reg_b),
        .concluido   (concluido_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ecount <= ecount + 1;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
        n_vec++;
        if (atual !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nome, atual, req);
        end
    endtask

    task automatic fallo(input string nome);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event at cycle %0d", nome, ecount);
    endtask

    // Monitor: every concluido pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        esperado_t e;
        if (!reset) begin
            if (concluido_a) begin
                if (fila_a.size() == 0) begin
                    fallo("a_spurious_concluido");
                end else begin
                    e = fila_a.pop_front();
                    check("a_registrador", {16'h0, reg_a}, {16'h0, e.val});
                    check("a_latency", ecount, e.cyc);
                end
            end
            if (concluido_b) begin
                if (fila_b.size() == 0) begin
                    fallo("b_spurious_concluido");
                end else begin
                    e = fila_b.pop_front();
                    check("b_registrador", {16'h0, reg_b}, {16'h0, e.val});
                    check("b_latency", ecount, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic [13:0] v, input logic [15:0] ea, input logic [15:0] eb);
        int g = 0;
        @(negedge clock);
        while (!(pronto_a && pronto_b) && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (g >= 100) fallo("send_timeout");
        entrada = v;
        valido  = 1'b1;
        fila_a.push_back('{ea, ecount + 16});
        fila_b.push_back('{eb, ecount + 16});
        @(negedge clock);
        valido = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((fila_a.size() + fila_b.size()) != 0 && g < 60) begin
            @(negedge clock);
            g++;
        end
        check("queue_drained", fila_a.size() + fila_b.size(), 0);
    endtask

    initial begin
        int cnt;
        reset   = 1'b1;
        valido  = 1'b0;
        entrada = '0;
        repeat (3) @(negedge clock);
        check("reset_reg_a", {16'h0, reg_a}, 32'h0);
        check("reset_reg_b", {16'h0, reg_b}, 32'h0);
        check("reset_pronto", {30'h0, pronto_a, pronto_b}, 32'h3);
        check("reset_concluido", {30'h0, concluido_a, concluido_b}, 32'h0);
        reset = 1'b0;

        // Basic conversion and busy window length
        send(14'd1234, 16'h1234, 16'h1234);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (pronto_a) break;
            cnt++;
            @(negedge clock);
        end
        check("pronto_low_cycles", cnt, 15);

        // Range limits and blanking
        send(14'd9999,  16'h9999, 16'h9999);
        send(14'd0,     16'h0000, 16'hFFF0);
        send(14'd10000, 16'hFFFF, 16'hFFFF);
        send(14'd16383, 16'hFFFF, 16'hFFFF);
        send(14'd7,     16'h0007, 16'hFFF7);
        send(14'd305,   16'h0305, 16'hF305);
        send(14'd1000,  16'h1000, 16'h1000);
        drain();

        // Handshake: valido held high, entrada changing every cycle
        fila_a.push_back('{16'h0010, ecount + 16});
        fila_a.push_back('{16'h0026, ecount + 32});
        fila_a.push_back('{16'h0042, ecount + 48});
        fila_b.push_back('{16'hFF10, ecount + 16});
        fila_b.push_back('{16'hFF26, ecount + 32});
        fila_b.push_back('{16'hFF42, ecount + 48});
        for (int i = 0; i < 48; i++) begin
            entrada = 14'(10 + i);
            valido  = 1'b1;
            if (i == 24) begin
                check("hold_a_1", {16'h0, reg_a}, 32'h0010);
                check("hold_b_1", {16'h0, reg_b}, 32'hFF10);
            end
            if (i == 40) begin
                check("hold_a_2", {16'h0, reg_a}, 32'h0026);
                check("hold_b_2", {16'h0, reg_b}, 32'hFF26);
            end
            @(negedge clock);
        end
        valido = 1'b0;
        drain();

        // Reset on the 5th CONVERTE edge of a 4321 conversion
        @(negedge clock);
        entrada = 14'd4321;
        valido  = 1'b1;
        @(negedge clock);
        valido = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_reg_a", {16'h0, reg_a}, 32'h0);
        check("abort_reg_b", {16'h0, reg_b}, 32'h0);
        check("abort_pronto", {30'h0, pronto_a, pronto_b}, 32'h3);
        check("abort_concluido", {30'h0, concluido_a, concluido_b}, 32'h0);
        repeat (20) @(negedge clock);
        send(14'd42, 16'h0042, 16'hFF42);
        drain();

        // Reset collides with acceptance
        @(negedge clock);
        reset   = 1'b1;
        valido  = 1'b1;
        entrada = 14'd99;
        @(negedge clock);
        reset  = 1'b0;
        valido = 1'b0;
        check("collision_pronto_0", {30'h0, pronto_a, pronto_b}, 32'h3);
        @(negedge clock);
        check("collision_pronto_1", {30'h0, pronto_a, pronto_b}, 32'h3);
        repeat (20) @(negedge clock);
        check("collision_reg_a", {16'h0, reg_a}, 32'h0);
        check("collision_reg_b", {16'h0, reg_b}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", ecount);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conversor_bcd.md
# conversor_bcd

Sequential binary-to-BCD converter and display-register controller. It accepts an unsigned binary value through a valid/ready handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then loads the 16-bit four-digit BCD `registrador` that drives the four-digit seven-segment decoder. Out-of-range values and optionally suppressed leading zeros are encoded as digit 4'hF, which the decoder shows as a blank digit.

## Interface
- `LARGURA`, 14: width of the binary input; legal range 4..14.
- `SUPRIME_ZEROS`, 0: when 1, leading zero digits 3..1 are replaced by 4'hF (blank).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `entrada`  in  LARGURA  unsigned binary value to convert.
- `valido`  in  1  `entrada` is valid.
- `pronto`  out  1  converter idle and able to accept; combinational from state (high only in OCIOSO).
- `registrador`  out  16  BCD result. Digit 3 is [15:12], digit 0 is [3:0]. Registered; holds its value between conversions.
- `concluido`  out  1  one-cycle pulse, high in the cycle after `registrador` is updated.

## Operation
- States: OCIOSO, CONVERTE, FIXA.
- OCIOSO:
  - `pronto`=1.
  - On an edge with `valido`=1, the block captures `entrada` into the shift register and clears the 16-bit BCD accumulator.
  - At the same edge it sets `contador` to LARGURA-1, stores `excesso` = (`entrada` > 9999), and moves to CONVERTE.
- CONVERTE:
  - Each edge applies add-3 to every accumulator digit ≥5, then shifts {accumulator, shift register} left by one.
  - `contador` decrements each edge. The edge at which `contador`=0 performs the last iteration and moves to FIXA.
  - Exactly LARGURA iterations are performed.
- FIXA, one edge:
  - If `excesso`, `registrador` ← 16'hFFFF.
  - Otherwise `registrador` ← accumulator, with leading-zero blanking applied when SUPRIME_ZEROS=1.
  - Blanking rule: digit k (k=3..1) becomes 4'hF if it and all higher digits are zero. Digit 0 is never blanked.
  - The same edge sets `concluido`=1 and moves to OCIOSO.
- `valido` outside OCIOSO is ignored. Nothing is queued, and `entrada` is sampled only at the acceptance edge.
- Arithmetic:
  - Accumulator is 16 bits, 4 digits.
  - Add-3 is a per-digit 4-bit add and never carries between digits.
  - For LARGURA ≤ 14 and values ≤ 9999, no digit exceeds 9.

## Timing
- Reset values: state OCIOSO, `pronto`=1, `registrador`=16'h0000, `concluido`=0, `contador`=0, `excesso`=0.
- Reset mid-conversion aborts the conversion. `registrador` returns to 16'h0000, no `concluido` is produced, and `pronto`=1 in the cycle after the reset edge.
- Latency: acceptance at edge E0 means `registrador` updates at edge E0+LARGURA+1. `concluido` is high during the cycle following that edge (LARGURA+1 cycles after acceptance).
- `pronto` is low from the cycle after E0 through the cycle after E0+LARGURA. It is high again in the cycle after E0+LARGURA+1.
- Earliest next acceptance is edge E0+LARGURA+2. Steady-state period is LARGURA+2 cycles (16 for the default).
- Reset has priority over every other event, including a simultaneous acceptance.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum {OCIOSO, CONVERTE, FIXA};
  - `DIGITO_APAGADO` = 4'hF;
  - `VALOR_MAXIMO` = 9999;
  - the BCD digit width constant 4.
- Sub-module `soma3`: combinational per-digit corrector (in ≥5 → in+3, else in). Instantiated four times on the accumulator.
- The FSM, counter, shift register, overflow flag and blanking logic stay in `conversor_bcd`.

## Test plan
- Basic conversion: after reset, apply `entrada`=1234 with `valido`=1 for one cycle.
  - `registrador`=16'h1234 exactly 15 edges after acceptance.
  - `concluido` is a single-cycle pulse.
  - `pronto` is low for 15 cycles.
- Range limits: 9999 → 16'h9999; 0 → 16'h0000; 10000 → 16'hFFFF; 16383 → 16'hFFFF. In every case `concluido` pulses once.
- Leading-zero blanking with SUPRIME_ZEROS=1: 7 → 16'hFFF7; 0 → 16'hFFF0; 305 → 16'hF305; 1000 → 16'h1000.
- Handshake: hold `valido`=1 with `entrada` changing every cycle (10, 11, 12, …).
  - Only the values present at edges where `pronto`=1 are converted.
  - Results appear every 16 cycles.
  - `registrador` holds its value between updates.
- Reset mid-conversion: assert `reset` on the 5th CONVERTE edge of a 4321 conversion.
  - `registrador`=16'h0000, no `concluido`, `pronto`=1 next cycle.
  - A following conversion of 42 yields 16'h0042.
- Reset collision: `reset` and `valido` both high at the same edge → no conversion starts and the state stays OCIOSO.
